// File: rtl/seven_seg_shift_out.sv
// -----------------------------------------------------------------------------
// seven_seg_shift_out
//
// Serialises a 64-bit seven-segment pattern (8 digits x 8 bits, digit 7 in
// bits [63:56]) onto an external shift-register display chain. One frame is
// 64 serial bits, MSB first, followed by a latch pulse on seg_pen. Frames
// are started by a level-sampled request. Holding start high refreshes the
// display continuously, with one idle cycle between frames.
//
// Parameters
//   DIV    : half-period of seg_clk in clk cycles (1..255)
//   INVERT : 1 = shift out ~data (active-low segments), 0 = data unchanged
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   data     in   64-bit segment pattern, sampled only at frame start
//   start    in   frame request, sampled in IDLE
//   busy     out  high while a frame is shifting or latching
//   done     out  one-cycle pulse after the latch completes
//   seg_clk  out  serial shift clock
//   seg_sout out  serial data, data[63] first
//   seg_pen  out  latch enable, high for DIV cycles at frame end
//   seg_clrn out  display chain clear, active-low
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module seven_seg_shift_out #(
    parameter int unsigned DIV    = 2,
    parameter bit          INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Terminal value of the divider in every phase.
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    // Polarity applied to the captured frame word.
    function automatic logic [63:0] frame_word(input logic [63:0] d);
        return INVERT ? ~d : d;
    endfunction

    state_e      state_q,    state_d;
    phase_e      phase_q,    phase_d;
    logic [63:0] shreg_q,    shreg_d;
    logic [5:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  div_cnt_q,  div_cnt_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        seg_clk_q,  seg_clk_d;
    logic        seg_sout_q, seg_sout_d;
    logic        seg_pen_q,  seg_pen_d;
    logic        seg_clrn_q, seg_clrn_d;
    logic [63:0] word_s;

    // Frame word as it would be captured this cycle.
    always_comb begin
        word_s = frame_word(data);
    end

    // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        seg_clk_d  = seg_clk_q;
        seg_sout_d = seg_sout_q;
        seg_pen_d  = seg_pen_q;
        // Clear is released on the first edge after reset and never re-asserted.
        seg_clrn_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy_d    = 1'b0;
                seg_clk_d = 1'b0;
                seg_pen_d = 1'b0;
                // The seg_clrn_q term ignores start during the first cycle out of reset.
                if (start && seg_clrn_q) begin
                    shreg_d    = word_s;
                    seg_sout_d = word_s[63];
                    bit_cnt_d  = 6'd0;
                    div_cnt_d  = 8'd0;
                    phase_d    = PH_LOW;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    if (phase_q == PH_LOW) begin
                        // Data has been stable for DIV cycles; raise the shift clock.
                        seg_clk_d = 1'b1;
                        phase_d   = PH_HIGH;
                    end else begin
                        seg_clk_d = 1'b0;
                        phase_d   = PH_LOW;
                        if (bit_cnt_q == 6'd63) begin
                            // Last bit clocked: park data low and open the latch window.
                            seg_sout_d = 1'b0;
                            seg_pen_d  = 1'b1;
                            state_d    = ST_LATCH;
                        end else begin
                            // The next bit appears on the falling edge of seg_clk.
                            shreg_d    = {shreg_q[62:0], 1'b0};
                            seg_sout_d = shreg_q[62];
                            bit_cnt_d  = bit_cnt_q + 6'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_LATCH: begin
                seg_clk_d = 1'b0;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    seg_pen_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                seg_clk_d  = 1'b0;
                seg_sout_d = 1'b0;
                seg_pen_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_LOW;
            shreg_q    <= 64'd0;
            bit_cnt_q  <= 6'd0;
            div_cnt_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seg_clk_q  <= seg_clk_d;
            seg_sout_q <= seg_sout_d;
            seg_pen_q  <= seg_pen_d;
            seg_clrn_q <= seg_clrn_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign seg_clk  = seg_clk_q;
    assign seg_sout = seg_sout_q;
    assign seg_pen  = seg_pen_q;
    assign seg_clrn = seg_clrn_q;

endmodule
